sound_noise_sync: RTL and testbench
===================================

// Module: sound_noise_sync
// PURPOSE
//  Next-gen noise channel (APU ch4): parametrised LFSR noise, volume envelope and length counter in ONE clock domain.
//  Sequencer rates arrive as 1-cycle strobes. No derived clocks, no edge-triggered start.
//  Sits between the APU register file / frame sequencer and the channel mixer; output is a 4-bit level plus an enable.
// PARAMETERS
//  LFSR_W   15  LFSR width (wide mode)
//  NARROW_W 7   effective width in narrow mode; feedback also written to bit NARROW_W-1
//  LEN_W    6   length field width; length counter runs 2**LEN_W - length ticks
//  VOL_W    4   volume/level width
// PORTS
//  clk                  in  1        4.194304 MHz system clock
//  rst                  in  1        asynchronous reset, ACTIVE-LOW (0 = reset)
//  length_tick          in  1        256 Hz strobe, 1 clk wide
//  env_tick             in  1        64 Hz strobe, 1 clk wide
//  start                in  1        trigger strobe, 1 clk wide, synchronous
//  single               in  1        1 = stop when length expires
//  length               in  LEN_W    length load value
//  initial_volume       in  VOL_W    envelope start volume
//  envelope_increasing  in  1        1 = up, 0 = down
//  num_envelope_sweeps  in  3        env period in env_ticks; 0 = frozen
//  shift_clock_freq     in  4        s: shift prescaler exponent
//  counter_width        in  1        0 = LFSR_W bits, 1 = NARROW_W bits
//  freq_dividing_ratio  in  3        r: base divisor select
//  level                out VOL_W    channel output level
//  enable               out 1        channel active
// BEHAVIOUR
//  Reset (rst=0): lfsr=all ones, enable=0, level=0, volume=0, timer=0, len_ctr=0, env_ctr=0. All outputs are registered.
//  start: on the edge where start=1, latch r, s, counter_width and the envelope fields. Then:
//   - lfsr <= all ones, timer <= period, volume <= initial_volume
//   - env_ctr <= num_envelope_sweeps, len_ctr <= 2**LEN_W - length, enable <= 1
//  Period: divisor = (r==0) ? 8 : 16*r clocks; period = divisor << s.
//   - 20-bit down counter, reloaded on expiry. The LFSR steps on the expiry edge.
//   - First step falls exactly 'period' clocks after the start edge.
//   - s>=14: no step; the LFSR holds.
//  LFSR step: fb = lfsr[0]^lfsr[1]; lfsr <= {fb, lfsr[LFSR_W-1:1]}.
//   - Narrow mode also forces bit NARROW_W-1 to fb. Upper bits keep shifting; they are not cleared.
//  Output: level = (enable & ~lfsr[0]) ? volume : 0, registered, so it updates one clk after the lfsr/volume change.
//  Envelope: on env_tick with sweeps!=0, env_ctr decrements.
//   - When env_ctr reaches 0: reload it, then volume +/-1.
//   - Volume saturates at 2**VOL_W-1 or 0; once saturated, sweeping stops until the next start.
//  Length: on length_tick with single=1 and len_ctr!=0, len_ctr decrements.
//   - The transition to 0 clears enable on that edge.
//   - single=0: len_ctr holds and enable stays 1.
//  Simultaneous events:
//   - start wins over length_tick, env_tick and timer expiry in the same clk (ticks discarded).
//   - length expiry and LFSR step on the same edge: enable=0 takes priority, and level=0 on the next clk.
//  Reset mid-operation returns everything to reset values immediately, with no pending step.
//  enable=0 gates level to 0 but does not stop the LFSR/timer (matches hardware).
// CONFIGURATION
//  SOUND_NOISE_DAC_EN
//   - defined: the DAC is off when initial_volume==0 && !envelope_increasing.
//     A start in that state leaves enable=0, and enable drops to 0 on the cycle those fields are latched.
//   - undefined: enable is controlled only by start and the length counter.
// STRUCTURE
//  Shared include sound_defs.vh: divisor table (r -> clocks), VOL_MAX, SHIFT_STOP=14 localparams.
//  Sub-module sound_vol_env_sync: the synchronous envelope (volume, env_ctr, saturation), also reused by ch1/ch2.
//  Timer, LFSR, length counter and output mux stay in this module.
// TESTING
//  1 Reset: rst=0 mid-run -> level=0 and enable=0 at once; lfsr=0x7FFF after release.
//  2 Wide mode: r=0, s=0, w=0, vol=0xF, start.
//    - Steps occur every 8 clk; lfsr=0x7FFF>>k for k<=14.
//    - Step 15 gives 0x4000, and level=0xF one clk later (start+121).
//  3 Narrow mode: r=1, s=0, w=1 -> the bit-0 sequence repeats every 127 steps (2032 clk); s=14 -> lfsr frozen.
//  4 Length: single=1, length=62 -> enable=0 on the 2nd length_tick.
//    - Same setup with single=0 -> enable stays 1 after 100 ticks.
//    - start coincident with length_tick -> len_ctr=2, enable=1.
//  5 Envelope: vol=0xF, down, n=1 -> volume 0 after 15 env_ticks and stays 0.
//    - vol=0xE, up, n=2 -> reaches 0xF after 2 ticks and holds.
//  6 SOUND_NOISE_DAC_EN: vol=0, down, start -> enable=0. Without the macro -> enable=1, level=0.

Source files
------------

// File: rtl/sound_noise_sync_pkg.sv
// Shared definitions for the noise channel.
// Contents:
//   TimerW, ShiftStop  - timer width and the first shift exponent that stops the LFSR
//   lfsr_width_e       - wide / narrow LFSR mode
//   noise_cfg_t        - frequency and width settings latched at start
//   noise_divisor()    - base divisor table (r -> clocks)
//   noise_period()     - divisor << s, or 0 when s disables stepping
package sound_noise_sync_pkg;

  localparam int unsigned TimerW    = 20;
  localparam int unsigned ShiftStop = 14;

  typedef enum logic [0:0] {
    WidthWide   = 1'b0,
    WidthNarrow = 1'b1
  } lfsr_width_e;

  typedef struct packed {
    logic [2:0]  ratio;
    logic [3:0]  shift;
    lfsr_width_e width;
  } noise_cfg_t;

  // r == 0 is the special half-step divisor of 8 clocks, otherwise 16*r.
  function automatic logic [TimerW-1:0] noise_divisor(input logic [2:0] r);
    logic [TimerW-1:0] div;
    if (r == 3'd0) begin
      div = TimerW'(8);
    end else begin
      div = TimerW'({r, 4'b0000});
    end
    return div;
  endfunction

  // A zero period parks the timer, so the LFSR holds for large shifts.
  function automatic logic [TimerW-1:0] noise_period(input logic [2:0] r, input logic [3:0] s);
    logic [TimerW-1:0] per;
    if (s >= 4'(ShiftStop)) begin
      per = '0;
    end else begin
      per = noise_divisor(r) << s;
    end
    return per;
  endfunction

endpackage

// File: rtl/sound_vol_env_sync.sv
// Synchronous volume envelope shared by the square and noise channels.
// Ports:
//   clk_i, rst_ni   - clock and asynchronous active-low reset
//   start_i         - trigger strobe; latches the envelope fields and loads the volume
//   env_tick_i      - envelope rate strobe (64 Hz, one clock wide)
//   init_vol_i      - start volume
//   increasing_i    - 1 = count up, 0 = count down
//   sweeps_i        - envelope period in env ticks, 0 = frozen
//   volume_o        - current volume (registered)
module sound_vol_env_sync #(
  parameter int unsigned VolW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            env_tick_i,
  input  logic [VolW-1:0] init_vol_i,
  input  logic            increasing_i,
  input  logic [2:0]      sweeps_i,
  output logic [VolW-1:0] volume_o
);

  localparam logic [VolW-1:0] VolMax = '1;

  logic [VolW-1:0] volume_q, volume_d;
  logic [2:0]      env_ctr_q, env_ctr_d;
  logic [2:0]      sweeps_q, sweeps_d;
  logic            inc_q, inc_d;
  logic            sat_q, sat_d;

  always_comb begin
    volume_d  = volume_q;
    env_ctr_d = env_ctr_q;
    sweeps_d  = sweeps_q;
    inc_d     = inc_q;
    sat_d     = sat_q;
    if (start_i) begin
      volume_d  = init_vol_i;
      env_ctr_d = sweeps_i;
      sweeps_d  = sweeps_i;
      inc_d     = increasing_i;
      sat_d     = 1'b0;
    end else if (env_tick_i && (sweeps_q != 3'd0) && !sat_q) begin
      if (env_ctr_q <= 3'd1) begin
        // Counter reaches zero: reload and move the volume one step.
        env_ctr_d = sweeps_q;
        if (inc_q) begin
          if (volume_q == VolMax) begin
            sat_d = 1'b1;
          end else begin
            volume_d = volume_q + VolW'(1);
            sat_d    = (volume_d == VolMax);
          end
        end else begin
          if (volume_q == '0) begin
            sat_d = 1'b1;
          end else begin
            volume_d = volume_q - VolW'(1);
            sat_d    = (volume_d == '0);
          end
        end
      end else begin
        env_ctr_d = env_ctr_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      volume_q  <= '0;
      env_ctr_q <= '0;
      sweeps_q  <= '0;
      inc_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      volume_q  <= volume_d;
      env_ctr_q <= env_ctr_d;
      sweeps_q  <= sweeps_d;
      inc_q     <= inc_d;
      sat_q     <= sat_d;
    end
  end

  assign volume_o = volume_q;

endmodule

// File: rtl/sound_noise_sync.sv
// APU noise channel (ch4): LFSR noise generator, volume envelope and length counter,
// all in the system clock domain with sequencer rates delivered as one-clock strobes.
// Ports:
//   clk, rst                 - system clock, asynchronous active-low reset
//   length_tick, env_tick    - 256 Hz / 64 Hz sequencer strobes
//   start                    - trigger strobe
//   single                   - stop the channel when the length counter expires
//   length                   - length load; counter runs 2**LEN_W - length ticks
//   initial_volume, envelope_increasing, num_envelope_sweeps - envelope setup
//   shift_clock_freq, counter_width, freq_dividing_ratio     - LFSR clocking / width
//   level                    - registered output level
//   enable                   - registered channel-active flag
// Build option: define SOUND_NOISE_DAC_EN to model the DAC power-off (a start with
// initial_volume == 0 and a decreasing envelope leaves the channel disabled).
module sound_noise_sync
  import sound_noise_sync_pkg::*;
#(
  parameter int unsigned LFSR_W   = 15,
  parameter int unsigned NARROW_W = 7,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned VOL_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             length_tick,
  input  logic             env_tick,
  input  logic             start,
  input  logic             single,
  input  logic [LEN_W-1:0] length,
  input  logic [VOL_W-1:0] initial_volume,
  input  logic             envelope_increasing,
  input  logic [2:0]       num_envelope_sweeps,
  input  logic [3:0]       shift_clock_freq,
  input  logic             counter_width,
  input  logic [2:0]       freq_dividing_ratio,
  output logic [VOL_W-1:0] level,
  output logic             enable
);

  localparam logic [LEN_W:0] LenFull = {1'b1, {LEN_W{1'b0}}};

  noise_cfg_t        cfg_q, cfg_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [LEN_W:0]    len_ctr_q, len_ctr_d;
  logic              enable_q, enable_d;
  logic [VOL_W-1:0]  level_q, level_d;
  logic [VOL_W-1:0]  volume;
  logic              fb;
  logic              dac_on;

`ifdef SOUND_NOISE_DAC_EN
  assign dac_on = (initial_volume != '0) || envelope_increasing;
`else
  assign dac_on = 1'b1;
`endif

  // Envelope fields are latched inside the envelope on the same start edge.
  sound_vol_env_sync #(
    .VolW (VOL_W)
  ) u_env (
    .clk_i        (clk),
    .rst_ni       (rst),
    .start_i      (start),
    .env_tick_i   (env_tick),
    .init_vol_i   (initial_volume),
    .increasing_i (envelope_increasing),
    .sweeps_i     (num_envelope_sweeps),
    .volume_o     (volume)
  );

  // Narrow mode mirrors the feedback into bit NARROW_W-1; the upper bits keep shifting.
  always_comb begin
    fb        = lfsr_q[0] ^ lfsr_q[1];
    lfsr_step = {fb, lfsr_q[LFSR_W-1:1]};
    if (cfg_q.width == WidthNarrow) begin
      lfsr_step[NARROW_W-1] = fb;
    end
  end

  always_comb begin
    cfg_d     = cfg_q;
    lfsr_d    = lfsr_q;
    timer_d   = timer_q;
    len_ctr_d = len_ctr_q;
    enable_d  = enable_q;
    if (start) begin
      // Start overrides any tick or timer expiry in the same clock.
      cfg_d.ratio = freq_dividing_ratio;
      cfg_d.shift = shift_clock_freq;
      cfg_d.width = lfsr_width_e'(counter_width);
      lfsr_d      = '1;
      timer_d     = noise_period(freq_dividing_ratio, shift_clock_freq);
      len_ctr_d   = LenFull - {1'b0, length};
      enable_d    = dac_on;
    end else begin
      // A zero timer is parked: nothing pending after reset or for large shifts.
      if (timer_q != '0) begin
        if (timer_q == TimerW'(1)) begin
          timer_d = noise_period(cfg_q.ratio, cfg_q.shift);
          lfsr_d  = lfsr_step;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      if (length_tick && single && (len_ctr_q != '0)) begin
        len_ctr_d = len_ctr_q - (LEN_W + 1)'(1);
        if (len_ctr_q == (LEN_W + 1)'(1)) begin
          enable_d = 1'b0;
        end
      end
    end
    level_d = (enable_q && !lfsr_q[0]) ? volume : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q     <= '0;
      lfsr_q    <= '1;
      timer_q   <= '0;
      len_ctr_q <= '0;
      enable_q  <= 1'b0;
      level_q   <= '0;
    end else begin
      cfg_q     <= cfg_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      len_ctr_q <= len_ctr_d;
      enable_q  <= enable_d;
      level_q   <= level_d;
    end
  end

  assign level  = level_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_sound_noise_sync.sv
// Scoreboard bench for sound_noise_sync: stimulus pushes (cycle, probe, value) entries,
// a negedge monitor pops and compares entries as their cycle is presented.
module tb_sound_noise_sync;

  localparam int KLevel  = 0;
  localparam int KEnable = 1;
  localparam int KLfsr   = 2;
  localparam int KVolume = 3;
  localparam int KLenCtr = 4;
  localparam int KLfsr7  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       length_tick = 1'b0;
  logic       env_tick = 1'b0;
  logic       start = 1'b0;
  logic       single = 1'b0;
  logic [5:0] length = '0;
  logic [3:0] initial_volume = '0;
  logic       envelope_increasing = 1'b0;
  logic [2:0] num_envelope_sweeps = '0;
  logic [3:0] shift_clock_freq = '0;
  logic       counter_width = 1'b0;
  logic [2:0] freq_dividing_ratio = '0;
  logic [3:0] level;
  logic       enable;

  sound_noise_sync dut (
    .clk                 (clk),
    .rst                 (rst),
    .length_tick         (length_tick),
    .env_tick            (env_tick),
    .start               (start),
    .single              (single),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .shift_clock_freq    (shift_clock_freq),
    .counter_width       (counter_width),
    .freq_dividing_ratio (freq_dividing_ratio),
    .level               (level),
    .enable              (enable)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          kind;
    int unsigned exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int unsigned probe(input int kind);
    int unsigned v;
    case (kind)
      KLevel:  v = 32'(level);
      KEnable: v = 32'(enable);
      KLfsr:   v = 32'(dut.lfsr_q);
      KVolume: v = 32'(dut.u_env.volume_q);
      KLenCtr: v = 32'(dut.len_ctr_q);
      default: v = 32'(dut.lfsr_q[6:0]);
    endcase
    return v;
  endfunction

  task automatic sb_push(input int unsigned at, input int kind, input int unsigned v,
                         input string name);
    sb.push_back('{at: at, kind: kind, exp: v, name: name});
  endtask

  // Monitor: compare every entry whose cycle has come up.
  always @(negedge clk) begin
    int unsigned act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checks++;
        act = probe(sb[i].kind);
        if (sb[i].at < cyc) begin
          errors++;
          $display("FAIL %s: entry for cycle %0d not sampled (now %0d)", sb[i].name, sb[i].at, cyc);
        end else if (act != sb[i].exp) begin
          errors++;
          $display("FAIL %s @%0d: got 0x%0h, want 0x%0h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic arm_start(input logic [2:0] r, input logic [3:0] s, input logic w,
                           input logic [3:0] vol, input logic inc, input logic [2:0] n,
                           input logic sgl, input logic [5:0] len, output int unsigned s0);
    @(negedge clk);
    freq_dividing_ratio = r;
    shift_clock_freq    = s;
    counter_width       = w;
    initial_volume      = vol;
    envelope_increasing = inc;
    num_envelope_sweeps = n;
    single              = sgl;
    length              = len;
    start               = 1'b1;
    s0                  = cyc + 1;
  endtask

  task automatic arm_len_tick(output int unsigned e);
    @(negedge clk);
    length_tick = 1'b1;
    e = cyc + 1;
  endtask

  task automatic arm_env_tick(output int unsigned e);
    @(negedge clk);
    env_tick = 1'b1;
    e = cyc + 1;
  endtask

  task automatic clear_strobes();
    @(negedge clk);
    start       = 1'b0;
    length_tick = 1'b0;
    env_tick    = 1'b0;
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, e, t;

    // Reset values and release.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_push(cyc + 1, KLfsr, 32'h7FFF, "rst_lfsr");
    sb_push(cyc + 1, KEnable, 0, "rst_enable");
    sb_push(cyc + 1, KLevel, 0, "rst_level");
    sb_push(cyc + 6, KLfsr, 32'h7FFF, "idle_lfsr_holds");

    // Wide mode, period 8.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0, 6'd0, s0);
    sb_push(s0, KEnable, 1, "wide_enable");
    sb_push(s0, KLfsr, 32'h7FFF, "wide_lfsr_load");
    sb_push(s0 + 7, KLfsr, 32'h7FFF, "wide_no_early_step");
    for (int k = 1; k <= 14; k++) begin
      sb_push(s0 + 8 * k, KLfsr, 32'h7FFF >> k, $sformatf("wide_step%0d", k));
    end
    sb_push(s0 + 120, KLfsr, 32'h4000, "wide_step15");
    sb_push(s0 + 120, KLevel, 0, "wide_level_before");
    sb_push(s0 + 121, KLevel, 32'hF, "wide_level_after");
    clear_strobes();
    wait_until(s0 + 130);

    // Asynchronous reset mid-run (level is 0xF here).
    @(posedge clk);
    #2;
    rst = 1'b0;
    t = cyc;
    sb_push(t, KLevel, 0, "midrst_level");
    sb_push(t, KEnable, 0, "midrst_enable");
    sb_push(t, KLfsr, 32'h7FFF, "midrst_lfsr");
    @(negedge clk);
    rst = 1'b1;
    sb_push(cyc + 20, KLfsr, 32'h7FFF, "midrst_no_pending_step");
    wait_until(cyc + 22);

    // Narrow mode, period 16.
    arm_start(3'd1, 4'd0, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0, 6'd0, s0);
    sb_push(s0 + 16, KLfsr, 32'h3FBF, "narrow_step1");
    sb_push(s0 + 32, KLfsr, 32'h1F9F, "narrow_step2");
    sb_push(s0 + 2032, KLfsr7, 32'h7F, "narrow_period127");
    clear_strobes();
    wait_until(s0 + 2034);

    // Shift 14 freezes the LFSR.
    arm_start(3'd1, 4'd14, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0, 6'd0, s0);
    sb_push(s0, KLfsr, 32'h7FFF, "frozen_load");
    sb_push(s0 + 300, KLfsr, 32'h7FFF, "frozen_hold");
    clear_strobes();
    wait_until(s0 + 302);

    // Length counter, single shot, 2 ticks.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b1, 6'd62, s0);
    sb_push(s0, KLenCtr, 2, "len_load");
    clear_strobes();
    arm_len_tick(e);
    sb_push(e, KEnable, 1, "len_tick1_enable");
    sb_push(e, KLenCtr, 1, "len_tick1_ctr");
    clear_strobes();
    arm_len_tick(e);
    sb_push(e, KEnable, 0, "len_tick2_enable");
    sb_push(e, KLenCtr, 0, "len_tick2_ctr");
    sb_push(e + 1, KLevel, 0, "len_expired_level");
    clear_strobes();
    arm_len_tick(e);
    sb_push(e, KLenCtr, 0, "len_ctr_stays0");
    clear_strobes();

    // single = 0: counter holds through 100 ticks.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0, 6'd62, s0);
    clear_strobes();
    for (int k = 0; k < 100; k++) begin
      arm_len_tick(e);
      clear_strobes();
    end
    sb_push(cyc + 1, KEnable, 1, "cont_enable");
    sb_push(cyc + 1, KLenCtr, 2, "cont_ctr");
    @(negedge clk);

    // Start coincident with length_tick: the tick is discarded.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b1, 6'd62, s0);
    length_tick = 1'b1;
    sb_push(s0, KLenCtr, 2, "start_tick_ctr");
    sb_push(s0, KEnable, 1, "start_tick_enable");
    clear_strobes();

    // Length expiry on the same edge as LFSR step 15.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b1, 6'd63, s0);
    clear_strobes();
    wait_until(s0 + 118);
    arm_len_tick(e);
    sb_push(s0 + 120, KEnable, 0, "coinc_enable");
    sb_push(s0 + 120, KLfsr, 32'h4000, "coinc_lfsr");
    sb_push(s0 + 121, KLevel, 0, "coinc_level");
    clear_strobes();

    // Envelope down from 0xF, one tick per step.
    arm_start(3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 3'd1, 1'b0, 6'd0, s0);
    sb_push(s0, KVolume, 32'hF, "envdn_load");
    clear_strobes();
    for (int k = 1; k <= 18; k++) begin
      arm_env_tick(e);
      sb_push(e, KVolume, (k <= 15) ? 32'(15 - k) : 0, $sformatf("envdn_tick%0d", k));
      clear_strobes();
    end

    // Envelope up from 0xE, two ticks per step, saturates at 0xF.
    arm_start(3'd0, 4'd0, 1'b0, 4'hE, 1'b1, 3'd2, 1'b0, 6'd0, s0);
    clear_strobes();
    arm_env_tick(e);
    sb_push(e, KVolume, 32'hE, "envup_tick1");
    clear_strobes();
    arm_env_tick(e);
    sb_push(e, KVolume, 32'hF, "envup_tick2");
    clear_strobes();
    for (int k = 3; k <= 6; k++) begin
      arm_env_tick(e);
      sb_push(e, KVolume, 32'hF, $sformatf("envup_tick%0d", k));
      clear_strobes();
    end

    // Volume 0, decreasing: DAC option decides enable.
    arm_start(3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 6'd0, s0);
`ifdef SOUND_NOISE_DAC_EN
    sb_push(s0, KEnable, 0, "dac_enable");
`else
    sb_push(s0, KEnable, 1, "dac_enable");
`endif
    sb_push(s0 + 121, KLevel, 0, "dac_level");
    clear_strobes();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5000 && sb.size() != 0; k++) @(negedge clk);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never sampled (cycle %0d)", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
